dec_ascii_parser: RTL and testbench



---
 rtl/dec_parse_pkg.sv | 40 ++++
 rtl/dec_accum.sv | 47 ++++
 rtl/dec_ascii_parser.sv | 138 +++++++++++++
 tb/tb_dec_ascii_parser.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/dec_parse_pkg.sv
// rtl/dec_parse_pkg.sv - shared types, ASCII constants and character classifiers for the decimal parser
package dec_parse_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SIGN,
        ST_DIGIT,
        ST_SKIP,
        ST_OUT
    } state_t;

    typedef enum logic [1:0] {
        ERR_OK       = 2'd0,
        ERR_OVERFLOW = 2'd1,
        ERR_BADCHAR  = 2'd2,
        ERR_EMPTY    = 2'd3
    } err_t;

    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_9     = 8'h39;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_PLUS  = 8'h2B;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_COMMA = 8'h2C;

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= ASCII_0) && (c <= ASCII_9);
    endfunction

    function automatic logic is_term(input logic [7:0] c);
        return (c == ASCII_SPACE) || (c == ASCII_LF) || (c == ASCII_CR) || (c == ASCII_COMMA);
    endfunction

    function automatic logic is_sign(input logic [7:0] c);
        return (c == ASCII_MINUS) || (c == ASCII_PLUS);
    endfunction

endpackage

// File: rtl/dec_accum.sv
// rtl/dec_accum.sv - registered magnitude*10+digit accumulator with sticky overflow against a signed limit
module dec_accum #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             neg_i,
    input  logic [3:0]       digit_i,
    output logic [WIDTH-1:0] mag_o,
    output logic             ovf_o
);

    localparam int XW = WIDTH + 4;

    logic [WIDTH-1:0] mag_q;
    logic             ovf_q;
    logic [XW-1:0]    prod;
    logic [XW-1:0]    half;
    logic [XW-1:0]    limit;

    // Checked in WIDTH+4 bits so mag*10+9 can never wrap before the compare.
    assign prod  = {4'b0000, mag_q} * XW'(10) + XW'(digit_i);
    assign half  = XW'(1) << (WIDTH - 1);
    assign limit = neg_i ? half : half - XW'(1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mag_q <= '0;
            ovf_q <= 1'b0;
        end else if (clr_i) begin
            mag_q <= '0;
            ovf_q <= 1'b0;
        end else if (en_i && !ovf_q) begin
            if (prod > limit) begin
                ovf_q <= 1'b1;
            end else begin
                mag_q <= prod[WIDTH-1:0];
            end
        end
    end

    assign mag_o = mag_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/dec_ascii_parser.sv
// rtl/dec_ascii_parser.sv - streaming ASCII decimal token to signed WIDTH-bit value parser
module dec_ascii_parser
    import dec_parse_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    input  logic [7:0]       in_data_i,
    output logic             in_ready_o,
    output logic             out_valid_o,
    output logic [WIDTH-1:0] out_value_o,
    output logic [1:0]       out_err_o,
    input  logic             out_ready_i
);

    state_t           state_q, state_d;
    err_t             err_q, err_d, fin_err;
    logic             neg_q, neg_d;
    logic             acc_en, acc_clr, load_out;
    logic [WIDTH-1:0] mag;
    logic             ovf;
    logic             xfer_in, xfer_out;
    logic             c_digit, c_term, c_sign;
    logic [WIDTH-1:0] out_value_q;
    err_t             out_err_q;

    assign in_ready_o  = (state_q != ST_OUT);
    assign out_valid_o = (state_q == ST_OUT);
    assign xfer_in     = in_valid_i && in_ready_o;
    assign xfer_out    = out_valid_o && out_ready_i;
    assign c_digit     = is_digit(in_data_i);
    assign c_term      = is_term(in_data_i);
    assign c_sign      = is_sign(in_data_i);

    dec_accum #(.WIDTH(WIDTH)) u_accum (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (acc_clr),
        .en_i    (acc_en),
        .neg_i   (neg_q),
        .digit_i (in_data_i[3:0]),
        .mag_o   (mag),
        .ovf_o   (ovf)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            err_q   <= ERR_OK;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            neg_q   <= neg_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        neg_d    = neg_q;
        acc_en   = 1'b0;
        acc_clr  = 1'b0;
        load_out = 1'b0;
        fin_err  = ERR_OK;
        case (state_q)
            ST_IDLE: if (xfer_in) begin
                if (c_sign) begin
                    state_d = ST_SIGN;
                    neg_d   = (in_data_i == ASCII_MINUS);
                end else if (c_digit) begin
                    state_d = ST_DIGIT;
                    acc_en  = 1'b1;
                end else if (!c_term) begin
                    state_d = ST_SKIP;
                    err_d   = ERR_BADCHAR;
                end
            end
            ST_SIGN: if (xfer_in) begin
                if (c_digit) begin
                    state_d = ST_DIGIT;
                    acc_en  = 1'b1;
                end else if (c_term) begin
                    state_d  = ST_OUT;
                    load_out = 1'b1;
                    fin_err  = ERR_EMPTY;
                end else begin
                    state_d = ST_SKIP;
                    err_d   = ERR_BADCHAR;
                end
            end
            // An overflow already latched is the earlier error, so it outranks BADCHAR.
            ST_DIGIT: if (xfer_in) begin
                if (c_digit) begin
                    acc_en = 1'b1;
                end else if (c_term) begin
                    state_d  = ST_OUT;
                    load_out = 1'b1;
                    fin_err  = ovf ? ERR_OVERFLOW : ERR_OK;
                end else begin
                    state_d = ST_SKIP;
                    err_d   = ovf ? ERR_OVERFLOW : ERR_BADCHAR;
                end
            end
            ST_SKIP: if (xfer_in && c_term) begin
                state_d  = ST_OUT;
                load_out = 1'b1;
                fin_err  = err_q;
            end
            ST_OUT: if (xfer_out) begin
                state_d = ST_IDLE;
                acc_clr = 1'b1;
                neg_d   = 1'b0;
                err_d   = ERR_OK;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_value_q <= '0;
            out_err_q   <= ERR_OK;
        end else if (load_out) begin
            out_err_q   <= fin_err;
            out_value_q <= (fin_err != ERR_OK) ? '0 : (neg_q ? -mag : mag);
        end else if (xfer_out) begin
            out_value_q <= '0;
            out_err_q   <= ERR_OK;
        end
    end

    assign out_value_o = out_value_q;
    assign out_err_o   = out_err_q;

endmodule

// File: tb/tb_dec_ascii_parser.sv
// tb/tb_dec_ascii_parser.sv - directed self-checking bench over 32/8/16/64-bit parser instances
module tb_dec_ascii_parser;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;
    int         sel;
    int         vectors = 0;
    int         miscompares = 0;

    always #5 clk = ~clk;

    logic ir32, ov32, ir8, ov8, ir16, ov16, ir64, ov64;
    logic [31:0] v32;
    logic [7:0]  v8;
    logic [15:0] v16;
    logic [63:0] v64;
    logic [1:0]  e32, e8, e16, e64;

    logic        ir, ov;
    logic [63:0] val;
    logic [1:0]  err;

    dec_ascii_parser #(.WIDTH(32)) u32 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid && sel == 0), .in_data_i(in_data),
        .in_ready_o(ir32), .out_valid_o(ov32), .out_value_o(v32), .out_err_o(e32),
        .out_ready_i(out_ready && sel == 0));
    dec_ascii_parser #(.WIDTH(8)) u8 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid && sel == 1), .in_data_i(in_data),
        .in_ready_o(ir8), .out_valid_o(ov8), .out_value_o(v8), .out_err_o(e8),
        .out_ready_i(out_ready && sel == 1));
    dec_ascii_parser #(.WIDTH(16)) u16 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid && sel == 2), .in_data_i(in_data),
        .in_ready_o(ir16), .out_valid_o(ov16), .out_value_o(v16), .out_err_o(e16),
        .out_ready_i(out_ready && sel == 2));
    dec_ascii_parser #(.WIDTH(64)) u64 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid && sel == 3), .in_data_i(in_data),
        .in_ready_o(ir64), .out_valid_o(ov64), .out_value_o(v64), .out_err_o(e64),
        .out_ready_i(out_ready && sel == 3));

    always_comb begin
        ir = ir32; ov = ov32; val = {{32{v32[31]}}, v32}; err = e32;
        case (sel)
            1: begin ir = ir8;  ov = ov8;  val = {{56{v8[7]}}, v8};    err = e8;  end
            2: begin ir = ir16; ov = ov16; val = {{48{v16[15]}}, v16}; err = e16; end
            3: begin ir = ir64; ov = ov64; val = v64;                  err = e64; end
            default: ;
        endcase
    end

    task automatic send_str(input string s, output int early);
        int cnt;
        early = 0;
        for (int i = 0; i < s.len(); i++) begin
            in_valid = 1'b1;
            in_data  = s[i];
            cnt = 0;
            while (!ir && cnt < 20) begin
                @(posedge clk); #1;
                cnt++;
            end
            if (!ir) begin
                vectors++;
                miscompares++;
                $display("FAIL ready_timeout: in_ready got %b required 1 (sel %0d)", ir, sel);
            end
            @(posedge clk); #1;
            if (i < s.len() - 1 && ov) early++;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1; sel = 0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            sel = k;
            #1;
            vectors++;
            if (ir !== 1'b1 || ov !== 1'b0 || val !== 64'd0 || err !== 2'd0) begin
                miscompares++;
                $display("FAIL reset_state[%0d]: got ir=%b ov=%b val=%h err=%0d required ir=1 ov=0 val=0 err=0", k, ir, ov, val, err);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_width32();
        int early;
        sel = 0;
        send_str("-12345678\n", early);
        vectors++;
        if (ov !== 1'b1 || val !== 64'hFFFF_FFFF_FF43_9EB2 || err !== 2'd0 || early != 0) begin
            miscompares++;
            $display("FAIL w32_neg: got ov=%b val=%h err=%0d early=%0d required ov=1 val=ffffffffff439eb2 err=0 early=0", ov, val, err, early);
        end
        @(posedge clk); #1;
        vectors++;
        if (ov !== 1'b0 || ir !== 1'b1) begin
            miscompares++;
            $display("FAIL w32_consume: got ov=%b ir=%b required ov=0 ir=1", ov, ir);
        end
    endtask

    task automatic run_table(input int s_sel, input string name, input string toks[$],
                             input logic [63:0] vals[$], input logic [1:0] errs[$]);
        int early;
        sel = s_sel;
        for (int i = 0; i < toks.size(); i++) begin
            send_str(toks[i], early);
            vectors++;
            if (ov !== 1'b1 || val !== vals[i] || err !== errs[i] || early != 0) begin
                miscompares++;
                $display("FAIL %s[%0d]: got ov=%b val=%h err=%0d early=%0d required ov=1 val=%h err=%0d early=0",
                         name, i, ov, val, err, early, vals[i], errs[i]);
            end
            @(posedge clk); #1;
            vectors++;
            if (ov !== 1'b0 || ir !== 1'b1) begin
                miscompares++;
                $display("FAIL %s_consume[%0d]: got ov=%b ir=%b required ov=0 ir=1", name, i, ov, ir);
            end
        end
    endtask

    task automatic test_width8();
        string       toks[$] = '{"-128 ", "127,", "128 ", "-129\015", "300x "};
        logic [63:0] vals[$] = '{64'hFFFF_FFFF_FFFF_FF80, 64'd127, 64'd0, 64'd0, 64'd0};
        logic [1:0]  errs[$] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1};
        run_table(1, "w8", toks, vals, errs);
    endtask

    task automatic test_width16();
        string       toks[$] = '{"12a4\n", "7\n", "-\n", "  +42 ", "007\n", "-0\n"};
        logic [63:0] vals[$] = '{64'd0, 64'd7, 64'd0, 64'd42, 64'd7, 64'd0};
        logic [1:0]  errs[$] = '{2'd2, 2'd0, 2'd3, 2'd0, 2'd0, 2'd0};
        run_table(2, "w16", toks, vals, errs);
    endtask

    task automatic test_width64();
        string       toks[$] = '{"-9223372036854775808\n", "9223372036854775808\n", "9223372036854775807\n"};
        logic [63:0] vals[$] = '{64'h8000_0000_0000_0000, 64'd0, 64'h7FFF_FFFF_FFFF_FFFF};
        logic [1:0]  errs[$] = '{2'd0, 2'd1, 2'd0};
        run_table(3, "w64", toks, vals, errs);
    endtask

    task automatic test_backpressure();
        int early;
        sel = 2;
        out_ready = 1'b0;
        send_str("99\n", early);
        for (int c = 0; c < 5; c++) begin
            vectors++;
            if (ov !== 1'b1 || val !== 64'd99 || err !== 2'd0 || ir !== 1'b0) begin
                miscompares++;
                $display("FAIL backpressure_hold[%0d]: got ov=%b val=%h err=%0d ir=%b required ov=1 val=63 err=0 ir=0", c, ov, val, err, ir);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (ov !== 1'b0 || ir !== 1'b1) begin
            miscompares++;
            $display("FAIL backpressure_release: got ov=%b ir=%b required ov=0 ir=1", ov, ir);
        end
    endtask

    task automatic test_reset_mid_token();
        int early;
        sel = 1;
        send_str("-45", early);
        vectors++;
        if (ov !== 1'b0) begin
            miscompares++;
            $display("FAIL midtok_no_out: got ov=%b required 0", ov);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (ir !== 1'b1 || ov !== 1'b0 || val !== 64'd0 || err !== 2'd0) begin
            miscompares++;
            $display("FAIL midtok_in_reset: got ir=%b ov=%b val=%h err=%0d required ir=1 ov=0 val=0 err=0", ir, ov, val, err);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        send_str("6\n", early);
        vectors++;
        if (ov !== 1'b1 || val !== 64'd6 || err !== 2'd0) begin
            miscompares++;
            $display("FAIL midtok_after: got ov=%b val=%h err=%0d required ov=1 val=6 err=0", ov, val, err);
        end
        @(posedge clk); #1;
        vectors++;
        if (ov !== 1'b0 || ir !== 1'b1) begin
            miscompares++;
            $display("FAIL midtok_single: got ov=%b ir=%b required ov=0 ir=1", ov, ir);
        end
    endtask

    initial begin
        test_reset();
        test_width32();
        test_width8();
        test_width16();
        test_backpressure();
        test_reset_mid_token();
        test_width64();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
